// File: rtl/axi_read_responder_if.sv
// AXI4 read-channel bundle (AR request + R beat) between a master and the responder.
interface axi_read_responder_if;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        rlast;

  modport master (
    output araddr, arvalid, arlen, arsize, arburst, rready,
    input  arready, rdata, rresp, rvalid, rlast
  );

  modport slave (
    input  araddr, arvalid, arlen, arsize, arburst, rready,
    output arready, rdata, rresp, rvalid, rlast
  );
endinterface

// File: rtl/axi_read_responder.sv
// AXI4 read-only slave backed by a preloadable array of 64-bit words.
// One burst at a time; beats come from a registered read of the array, with
// FIXED/INCR/WRAP address sequencing and SLVERR/DECERR reporting.
module axi_read_responder #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  axi_read_responder_if.slave  s_axi,
  input  logic                 mem_we,
  input  logic [63:0]          mem_waddr,
  input  logic [63:0]          mem_wdata
);

  localparam int          AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [63:0] WORDS64 = 64'(MEM_WORDS);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_next;

  logic [63:0] mem [MEM_WORDS];

  // Context of the beat currently presented on R
  logic [63:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic [1:0]  burst_q;
  logic        err_q;
  logic [63:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;

  logic        ar_hs;
  logic        r_hs;
  logic        ar_err;
  logic        load_en;
  logic        load_err;
  logic        load_in_range;
  logic [63:0] wrap_mask;
  logic [63:0] next_addr;
  logic [63:0] load_addr;
  logic [63:0] load_idx;
  logic [63:0] load_word;
  logic [63:0] wr_idx;

  assign ar_hs  = s_axi.arvalid && s_axi.arready;
  assign r_hs   = s_axi.rvalid && s_axi.rready;
  assign wr_idx = (mem_waddr - BASE_ADDR) >> 3;

  // Pick the address of the next beat to load and look its word up in the array
  always_comb begin
    ar_err = (s_axi.arsize != 3'd3) || (s_axi.arburst == 2'd3) ||
             ((s_axi.arburst == BURST_WRAP) &&
              !(s_axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    wrap_mask = {53'd0, len_q, 3'b111};
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_INCR:  next_addr = addr_q + 64'd8;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + 64'd8) & wrap_mask);
      default:     next_addr = addr_q;
    endcase
    load_en       = ar_hs || (r_hs && !rlast_q);
    load_addr     = ar_hs ? (s_axi.araddr & ~64'h7) : next_addr;
    load_err      = ar_hs ? ar_err : err_q;
    load_idx      = (load_addr - BASE_ADDR) >> 3;
    load_in_range = load_idx < WORDS64;
    load_word     = mem[load_idx[AW-1:0]];
  end

  // Preload port; the array is deliberately left untouched by reset
  always_ff @(posedge clk) begin
    if (mem_we && (wr_idx < WORDS64)) begin
      mem[wr_idx[AW-1:0]] <= mem_wdata;
    end
  end

  // Latch the burst on AR and register each beat as it is loaded
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= 64'd0;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
      burst_q <= 2'd0;
      err_q   <= 1'b0;
      rdata_q <= 64'd0;
      rresp_q <= RESP_OKAY;
      rlast_q <= 1'b0;
    end else if (load_en) begin
      addr_q <= load_addr;
      err_q  <= load_err;
      if (ar_hs) begin
        len_q   <= s_axi.arlen;
        burst_q <= s_axi.arburst;
        beat_q  <= 8'd0;
        rlast_q <= (s_axi.arlen == 8'd0);
      end else begin
        beat_q  <= beat_q + 8'd1;
        rlast_q <= ((beat_q + 8'd1) == len_q);
      end
      if (load_err) begin
        rdata_q <= 64'd0;
        rresp_q <= RESP_SLVERR;
      end else if (!load_in_range) begin
        rdata_q <= 64'd0;
        rresp_q <= RESP_DECERR;
      end else begin
        rdata_q <= load_word;
        rresp_q <= RESP_OKAY;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: enter BURST on AR, leave on the final R handshake
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ar_hs) state_next = BURST;
      BURST:   if (r_hs && rlast_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs; arready is held low for as long as reset is asserted
  always_comb begin
    s_axi.arready = (state == IDLE) && reset;
    s_axi.rvalid  = (state == BURST);
    s_axi.rlast   = (state == BURST) && rlast_q;
    s_axi.rdata   = rdata_q;
    s_axi.rresp   = rresp_q;
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Self-checking bench for axi_read_responder: directed bursts plus randomized
// bursts, compared beat by beat against an address-arithmetic reference model.
module tb_axi_read_responder;

  localparam int          WORDS = 4096;
  localparam logic [63:0] BASE  = 64'h0;

  logic        clk;
  logic        reset;
  logic        mem_we;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;

  int total = 0;
  int bad   = 0;

  logic [63:0] ref_mem [WORDS];

  axi_read_responder_if bus ();

  axi_read_responder #(
    .MEM_WORDS (WORDS),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_axi     (bus),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the design stalls the sequence
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference beat: address from plain arithmetic on the burst rules, then lookup
  function automatic void modelBeat(input logic [63:0] addr, input int len, input logic [2:0] size,
                                    input logic [1:0] burst, input int beat,
                                    output logic [63:0] data, output logic [1:0] resp);
    logic [63:0] a0, a, span, base, idx;
    bit err;
    err  = (size != 3'd3) || (burst == 2'd3) ||
           ((burst == 2'd2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    a0   = addr & ~64'h7;
    span = 64'(len + 1) * 64'd8;
    base = 64'd0;
    case (burst)
      2'd0:    a = a0;
      2'd2: begin
        base = a0 - (a0 % span);
        a    = base + ((a0 - base + 64'(beat) * 64'd8) % span);
      end
      default: a = a0 + 64'(beat) * 64'd8;
    endcase
    idx = (a - BASE) / 64'd8;
    if (err) begin
      data = 64'd0;
      resp = 2'd2;
    end else if (idx >= 64'(WORDS)) begin
      data = 64'd0;
      resp = 2'd3;
    end else begin
      data = ref_mem[idx[11:0]];
      resp = 2'd0;
    end
  endfunction

  task automatic writeWord(input logic [63:0] addr, input logic [63:0] data);
    logic [63:0] idx;
    mem_we    = 1'b1;
    mem_waddr = addr;
    mem_wdata = data;
    idx = (addr - BASE) >> 3;
    if (idx < 64'(WORDS)) ref_mem[idx[11:0]] = data;
    @(negedge clk);
  endtask

  // Present an AR request and hold it until it is accepted (bounded)
  task automatic applyStimulus(input logic [63:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
    int budget;
    budget      = 0;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arsize  = size;
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("ar_handshake", 64'(bus.arready), 64'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
  endtask

  // Consume every beat of a burst; mode 0 rready=1, 1 pattern 1,0,0, 2 random
  task automatic collectBurst(input logic [63:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int mode);
    logic [63:0] d;
    logic [1:0]  r;
    bit          rr;
    int          cyc;
    int          stalls;
    cyc    = 0;
    stalls = 0;
    for (int i = 0; i <= int'(len); i++) begin
      modelBeat(addr, int'(len), size, burst, i, d, r);
      do begin
        case (mode)
          0:       rr = 1'b1;
          1:       rr = ((cyc % 3) == 0);
          default: rr = (stalls >= 3) || ($urandom_range(0, 2) != 0);
        endcase
        if (rr) stalls = 0; else stalls++;
        cyc++;
        bus.rready = rr;
        checkOutput("rvalid", 64'(bus.rvalid), 64'd1);
        checkOutput("rdata", bus.rdata, d);
        checkOutput("rresp", 64'(bus.rresp), 64'(r));
        checkOutput("rlast", 64'(bus.rlast), 64'(i == int'(len)));
        checkOutput("arready_busy", 64'(bus.arready), 64'd0);
        @(negedge clk);
      end while (!rr);
    end
    bus.rready = 1'b0;
    checkOutput("end_rvalid", 64'(bus.rvalid), 64'd0);
    checkOutput("end_rlast", 64'(bus.rlast), 64'd0);
    checkOutput("end_arready", 64'(bus.arready), 64'd1);
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0]  r;
    logic [63:0] old0;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          word;

    reset       = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = 64'd0;
    mem_wdata   = 64'd0;
    bus.araddr  = 64'd0;
    bus.arvalid = 1'b0;
    bus.arlen   = 8'd0;
    bus.arsize  = 3'd3;
    bus.arburst = 2'd1;
    bus.rready  = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_arready", 64'(bus.arready), 64'd0);
    checkOutput("rst_rvalid", 64'(bus.rvalid), 64'd0);
    checkOutput("rst_rlast", 64'(bus.rlast), 64'd0);
    checkOutput("rst_rresp", 64'(bus.rresp), 64'd0);
    checkOutput("rst_rdata", bus.rdata, 64'd0);

    $display("[TB] preload array while reset is held");
    for (int w = 0; w < WORDS; w++) begin
      writeWord(64'(w) * 64'd8, (w < 8) ? 64'h10 + 64'(w) : {$urandom, $urandom});
    end
    writeWord(64'h8000, 64'hDEAD_BEEF);
    mem_we = 1'b0;
    checkOutput("rst_hold_arready", 64'(bus.arready), 64'd0);

    reset = 1'b1;
    #1;
    checkOutput("release_arready", 64'(bus.arready), 64'd1);

    $display("[TB] INCR 8 beats, rready high");
    applyStimulus(64'h0, 8'd7, 3'd3, 2'd1);
    collectBurst(64'h0, 8'd7, 3'd3, 2'd1, 0);

    $display("[TB] INCR 8 beats, rready 1,0,0");
    applyStimulus(64'h0, 8'd7, 3'd3, 2'd1);
    collectBurst(64'h0, 8'd7, 3'd3, 2'd1, 1);

    $display("[TB] WRAP from 0x28");
    applyStimulus(64'h28, 8'd3, 3'd3, 2'd2);
    collectBurst(64'h28, 8'd3, 3'd3, 2'd2, 0);

    $display("[TB] INCR running off the top of the array");
    applyStimulus(64'h7FF0, 8'd3, 3'd3, 2'd1);
    collectBurst(64'h7FF0, 8'd3, 3'd3, 2'd1, 0);

    $display("[TB] error bursts");
    applyStimulus(64'h0, 8'd1, 3'd2, 2'd1);
    collectBurst(64'h0, 8'd1, 3'd2, 2'd1, 0);
    applyStimulus(64'h0, 8'd2, 3'd3, 2'd2);
    collectBurst(64'h0, 8'd2, 3'd3, 2'd2, 0);
    applyStimulus(64'h10, 8'd2, 3'd3, 2'd3);
    collectBurst(64'h10, 8'd2, 3'd3, 2'd3, 0);

    $display("[TB] FIXED with unaligned address");
    applyStimulus(64'h1D, 8'd3, 3'd3, 2'd0);
    collectBurst(64'h1D, 8'd3, 3'd3, 2'd0, 1);

    $display("[TB] AR held during a burst is stalled then accepted");
    applyStimulus(64'h40, 8'd3, 3'd3, 2'd1);
    bus.araddr  = 64'h100;
    bus.arlen   = 8'd1;
    bus.arsize  = 3'd3;
    bus.arburst = 2'd1;
    bus.arvalid = 1'b1;
    collectBurst(64'h40, 8'd3, 3'd3, 2'd1, 1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    collectBurst(64'h100, 8'd1, 3'd3, 2'd1, 0);

    $display("[TB] write to the word being loaded returns old data");
    old0        = ref_mem[0];
    bus.araddr  = 64'h0;
    bus.arlen   = 8'd1;
    bus.arsize  = 3'd3;
    bus.arburst = 2'd1;
    bus.arvalid = 1'b1;
    mem_we      = 1'b1;
    mem_waddr   = 64'h0;
    mem_wdata   = 64'hABCD_0123_4567_89EF;
    @(negedge clk);
    bus.arvalid = 1'b0;
    mem_we      = 1'b0;
    ref_mem[0]  = 64'hABCD_0123_4567_89EF;
    checkOutput("rbw_rvalid", 64'(bus.rvalid), 64'd1);
    checkOutput("rbw_old_data", bus.rdata, old0);
    bus.rready = 1'b1;
    @(negedge clk);
    checkOutput("rbw_beat1", bus.rdata, ref_mem[1]);
    checkOutput("rbw_beat1_last", 64'(bus.rlast), 64'd1);
    @(negedge clk);
    bus.rready = 1'b0;
    applyStimulus(64'h0, 8'd0, 3'd3, 2'd1);
    collectBurst(64'h0, 8'd0, 3'd3, 2'd1, 0);

    $display("[TB] reset in the middle of a burst");
    applyStimulus(64'h0, 8'd7, 3'd3, 2'd1);
    for (int i = 0; i < 3; i++) begin
      modelBeat(64'h0, 7, 3'd3, 2'd1, i, d, r);
      bus.rready = 1'b1;
      checkOutput("pre_rst_beat", bus.rdata, d);
      @(negedge clk);
    end
    bus.rready = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    checkOutput("midrst_rvalid", 64'(bus.rvalid), 64'd0);
    checkOutput("midrst_arready", 64'(bus.arready), 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("midrst_release_arready", 64'(bus.arready), 64'd1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("no_stray_beat", 64'(bus.rvalid), 64'd0);
    end
    applyStimulus(64'h20, 8'd3, 3'd3, 2'd1);
    collectBurst(64'h20, 8'd3, 3'd3, 2'd1, 0);

    $display("[TB] randomized bursts");
    for (int n = 0; n < 40; n++) begin
      word  = $urandom_range(0, WORDS + 7);
      addr  = 64'(word) * 64'd8 + 64'($urandom_range(0, 7));
      len   = 8'($urandom_range(0, 15));
      burst = 2'($urandom_range(0, 3));
      size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 2)) : 3'd3;
      if ($urandom_range(0, 3) == 0) begin
        writeWord(64'($urandom_range(0, WORDS - 1)) * 64'd8, {$urandom, $urandom});
        mem_we = 1'b0;
      end
      applyStimulus(addr, len, size, burst);
      collectBurst(addr, len, size, burst, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_responder.md
AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 Parameter MEM_WORDS, default 4096, the number of 64-bit words in the backing array.
REQ-002 Parameter BASE_ADDR, default 64'h0, the byte address of word 0.
REQ-003 clk  input  1  clock; all logic rises on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 s_axi_araddr  input  64  burst start byte address.
REQ-006 s_axi_arvalid  input  1  AR request valid.
REQ-007 s_axi_arready  output  1  AR request accepted.
REQ-008 s_axi_arlen  input  8  beats minus 1.
REQ-009 s_axi_arsize  input  3  beat size code; only 3 (8 bytes) is supported.
REQ-010 s_axi_arburst  input  2  burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
REQ-011 s_axi_rdata  output  64  beat data.
REQ-012 s_axi_rresp  output  2  beat response: 0 OKAY, 2 SLVERR, 3 DECERR.
REQ-013 s_axi_rvalid  output  1  beat valid.
REQ-014 s_axi_rready  input  1  beat accepted by master.
REQ-015 s_axi_rlast  output  1  final beat of the burst.
REQ-016 mem_we  input  1  preload write strobe.
REQ-017 mem_waddr  input  64  preload byte address.
REQ-018 mem_wdata  input  64  preload data.

Function
REQ-019 The block SHALL implement a two-state FSM: IDLE and BURST; only one burst is outstanding at a time.
REQ-020 In IDLE, s_axi_arready SHALL be 1; in BURST it SHALL be 0.
REQ-021 On an AR handshake (arvalid && arready), the block SHALL latch the address (bits [2:0] forced to 0), len, size and burst, and enter BURST.
REQ-022 Beat 0 SHALL appear with rvalid=1 on the cycle after the AR handshake; first-beat latency is 1 cycle.
REQ-023 The block SHALL hold rdata, rresp and rlast stable while rvalid && !rready.
REQ-024 On an R handshake of a non-final beat, the next beat SHALL be presented the following cycle with no bubble.
REQ-025 rlast SHALL be 1 only on beat index arlen; a burst SHALL deliver exactly arlen+1 beats.
REQ-026 On the R handshake of the final beat, the block SHALL drive rvalid=0 and rlast=0, return to IDLE, and drive arready=1 on the next cycle.
REQ-027 Address update for FIXED bursts: the address SHALL remain constant.
REQ-028 Address update for INCR bursts: the address SHALL advance by 8 per beat using a 64-bit wrapping add.
REQ-029 Address update for WRAP bursts: the address SHALL advance by 8 within a window of (arlen+1)*8 bytes aligned to that size, wrapping to the window base.
REQ-030 A WRAP burst with arlen not in {1,3,7,15} SHALL return SLVERR on every beat, with rdata=0.
REQ-031 An arsize other than 3, or arburst=3, SHALL return SLVERR on every beat, with rdata=0 and the full beat count.
REQ-032 A beat whose word index (addr-BASE_ADDR)>>3 lies outside [0, MEM_WORDS-1] SHALL return DECERR with rdata=0; in-range beats of the same burst SHALL return OKAY.
REQ-033 rdata SHALL be registered, read from the array at the cycle the beat is loaded.
REQ-034 When mem_we=1, mem_wdata SHALL be written to the in-range word at mem_waddr; out-of-range writes SHALL be ignored.
REQ-035 A write to a word in the same cycle that word is loaded for a beat SHALL yield the old data for that beat (read-before-write).
REQ-036 An AR presented while in BURST SHALL stall (arready=0) until the burst completes; the block SHALL not drop it.

Reset
REQ-037 When reset=0 at a posedge, the block SHALL enter IDLE and drive arready=0, rvalid=0, rlast=0, rresp=0, rdata=0.
REQ-038 On the first cycle after reset returns to 1, arready SHALL be 1.
REQ-039 Reset asserted mid-burst SHALL abandon the burst; no further beats of that burst SHALL be issued.
REQ-040 Array contents SHALL NOT be cleared by reset.
REQ-041 Preload writes SHALL be accepted while reset=0.

Verification
REQ-042 Preload words 0..7 with values 0x10..0x17, then issue AR addr=0x0, len=7, INCR, size=3, with rready=1 -> 8 consecutive beats 0x10..0x17, rlast on beat 7 only, rresp=0, arready=1 one cycle later.
REQ-043 Issue the same AR as REQ-042 with rready toggling 1,0,0,1,... -> every beat holds stable during stalls, and the data order is unchanged.
REQ-044 Issue AR addr=0x28, len=3, WRAP -> beats from words 5,6,7,4, rlast on word 4.
REQ-045 With MEM_WORDS=4096, issue AR addr=0x7FF0, len=3, INCR -> words 4094 and 4095 return OKAY, then 2 beats return DECERR with rdata=0.
REQ-046 Issue AR with size=2, len=1 -> 2 beats with SLVERR and rdata=0; separately, a WRAP burst with len=2 -> 3 beats with SLVERR.
REQ-047 Assert reset=0 after beat 2 of an 8-beat burst -> rvalid=0 the next cycle and arready=1 after release; a new AR then returns correct data.
